// File: rtl/dragon_body.sv
// Dragon body state: segment position chain, live-segment mask and ALIVE/DEAD FSM.
// Optional hit cooldown is built when DRAGON_HIT_COOLDOWN_EN is defined.

module dragon_slot #(
  parameter logic [7:0] SPAWN_POS = 8'h77
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       respawn,
  input  logic       shift_en,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         q <= SPAWN_POS;
    else if (respawn)  q <= SPAWN_POS;
    else if (shift_en) q <= d;
  end
endmodule

module dragon_body #(
  parameter int         INIT_LEN        = 3,
  parameter logic [7:0] SPAWN_POS       = 8'h77,
  parameter int         COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        head_move,
  input  logic [7:0]  head_pos,
  input  logic        sword_hit,
  input  logic        sheep_hit,
  input  logic        respawn,
  output logic [55:0] dragon_segment_positions,
  output logic [6:0]  active_dragon_segments,
  output logic [2:0]  dragon_length,
  output logic        dragon_dead,
  output logic        dragon_hurt
);
  localparam int         NUM_SLOTS = 7;
  localparam logic       ST_ALIVE  = 1'b0;
  localparam logic       ST_DEAD   = 1'b1;
  localparam logic [2:0] INIT_L    = 3'(INIT_LEN);

  function automatic logic [6:0] len_mask(input logic [2:0] l);
    logic [7:0] m;
    m = (8'd1 << l) - 8'd1;
    return m[6:0];
  endfunction

  logic       state_q;
  logic [2:0] len_q, len_nxt;
  logic [6:0] mask_q;
  logic       alive, shift_en, tick, grow, shrink, die, cd_idle;

  assign alive    = (state_q == ST_ALIVE);
  assign shift_en = head_move && alive;
  assign tick     = frame_tick && alive;

  // Every slot shifts on a move, live or not, so a grown tail lands where the old tail was.
  genvar i;
  generate
    for (i = 0; i < NUM_SLOTS; i++) begin : g_slot
      dragon_slot #(.SPAWN_POS(SPAWN_POS)) u_slot (
        .clk      (clk),
        .reset    (reset),
        .respawn  (respawn),
        .shift_en (shift_en),
        .d        ((i == 0) ? head_pos : dragon_segment_positions[8*(i-1) +: 8]),
        .q        (dragon_segment_positions[8*i +: 8])
      );
    end
  endgenerate

`ifdef DRAGON_HIT_COOLDOWN_EN
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);
  logic [7:0] cd_q;

  assign cd_idle = (cd_q == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cd_q <= 8'd0;
    else if (respawn)      cd_q <= 8'd0;
    else if (shrink)       cd_q <= CD_LOAD;
    else if (tick && !cd_idle) cd_q <= cd_q - 8'd1;
  end

  assign dragon_hurt = !cd_idle;
`else
  assign cd_idle     = 1'b1;
  assign dragon_hurt = 1'b0;
`endif

  assign grow   = tick && sheep_hit;
  assign shrink = tick && sword_hit && cd_idle;

  // Grow and shrink together cancel in length, but the shrink still arms the cooldown.
  always_comb begin
    len_nxt = len_q;
    die     = 1'b0;
    if (grow && !shrink) begin
      if (len_q != 3'd7) len_nxt = len_q + 3'd1;
    end else if (shrink && !grow) begin
      len_nxt = len_q - 3'd1;
      die     = (len_q == 3'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ALIVE;
      len_q   <= INIT_L;
      mask_q  <= len_mask(INIT_L);
    end else if (respawn) begin
      state_q <= ST_ALIVE;
      len_q   <= INIT_L;
      mask_q  <= len_mask(INIT_L);
    end else begin
      len_q  <= len_nxt;
      mask_q <= len_mask(len_nxt);
      if (die) state_q <= ST_DEAD;
    end
  end

  assign active_dragon_segments = mask_q;
  assign dragon_length          = len_q;
  assign dragon_dead            = (state_q == ST_DEAD);
endmodule

// File: tb/tb_dragon_body.sv
// Scoreboard bench for dragon_body: driver queues expected state, negedge monitor compares.
// Expectations for both builds of DRAGON_HIT_COOLDOWN_EN (COOLDOWN_FRAMES=2).
module tb_dragon_body;
`ifdef DRAGON_HIT_COOLDOWN_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif

  typedef struct {
    logic [55:0] pos;
    logic [6:0]  mask;
    logic [2:0]  len;
    logic        dead;
    logic        hurt;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        frame_tick = 0, head_move = 0, sword_hit = 0, sheep_hit = 0, respawn = 0;
  logic [7:0]  head_pos = 8'h00;
  logic [55:0] dragon_segment_positions;
  logic [6:0]  active_dragon_segments;
  logic [2:0]  dragon_length;
  logic        dragon_dead, dragon_hurt;

  int n_vec = 0;
  int n_bad = 0;
  exp_t q[$];

  localparam logic [55:0] A = 56'h77777777777777;
  localparam logic [55:0] P = 56'h77777777121314;

  dragon_body #(.INIT_LEN(3), .SPAWN_POS(8'h77), .COOLDOWN_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .head_move(head_move),
    .head_pos(head_pos), .sword_hit(sword_hit), .sheep_hit(sheep_hit), .respawn(respawn),
    .dragon_segment_positions(dragon_segment_positions),
    .active_dragon_segments(active_dragon_segments), .dragon_length(dragon_length),
    .dragon_dead(dragon_dead), .dragon_hurt(dragon_hurt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (dragon_segment_positions !== e.pos) begin
      n_bad++; $display("FAIL %s pos: got %h exp %h", name, dragon_segment_positions, e.pos);
    end
    if (active_dragon_segments !== e.mask) begin
      n_bad++; $display("FAIL %s mask: got %b exp %b", name, active_dragon_segments, e.mask);
    end
    if (dragon_length !== e.len) begin
      n_bad++; $display("FAIL %s len: got %0d exp %0d", name, dragon_length, e.len);
    end
    if (dragon_dead !== e.dead) begin
      n_bad++; $display("FAIL %s dead: got %b exp %b", name, dragon_dead, e.dead);
    end
    if (dragon_hurt !== e.hurt) begin
      n_bad++; $display("FAIL %s hurt: got %b exp %b", name, dragon_hurt, e.hurt);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("vec%0d", n_vec), e);
    end
  end

  // Drive one cycle of inputs, then queue the state expected after that edge.
  task automatic step(input logic hm, input logic [7:0] hp, input logic ft, input logic sw,
                      input logic sh, input logic rs, input logic [55:0] ep,
                      input logic [6:0] em, input logic [2:0] el, input logic ed, input logic eh);
    exp_t e;
    head_move = hm; head_pos = hp; frame_tick = ft; sword_hit = sw; sheep_hit = sh; respawn = rs;
    @(posedge clk);
    #1;
    e.pos = ep; e.mask = em; e.len = el; e.dead = ed; e.hurt = eh;
    q.push_back(e);
    head_move = 0; frame_tick = 0; sword_hit = 0; sheep_hit = 0; respawn = 0;
    @(negedge clk);
  endtask

  initial begin
    exp_t r;
    r.pos = A; r.mask = 7'h07; r.len = 3'd3; r.dead = 1'b0; r.hurt = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_held", r);
    reset = 1'b0;

    step(0, 8'h00, 0, 0, 0, 0, A,                  7'h07, 3'd3, 0, 0);
    step(1, 8'h12, 0, 0, 0, 0, 56'h77777777777712, 7'h07, 3'd3, 0, 0);
    step(1, 8'h13, 0, 0, 0, 0, 56'h77777777771213, 7'h07, 3'd3, 0, 0);
    step(1, 8'h14, 1, 0, 1, 0, P,                  7'h0f, 3'd4, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0, P,                  7'h1f, 3'd5, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0, P,                  7'h3f, 3'd6, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0, P,                  7'h7f, 3'd7, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0, P,                  7'h7f, 3'd7, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0, P,                  7'h7f, 3'd7, 0, 0);
    // respawn beats a same-cycle move
    step(1, 8'h55, 0, 0, 0, 1, A,                  7'h07, 3'd3, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0, A,                  7'h0f, 3'd4, 0, 0);
    step(0, 8'h00, 1, 1, 1, 0, A,                  7'h0f, 3'd4, 0, CD);
    step(0, 8'h00, 0, 0, 0, 1, A,                  7'h07, 3'd3, 0, 0);
    // sword on consecutive ticks from len 3
    step(0, 8'h00, 1, 1, 0, 0, A, 7'h03, 3'd2, 0, CD);
    step(0, 8'h00, 1, 1, 0, 0, A, CD ? 7'h03 : 7'h01, CD ? 3'd2 : 3'd1, 0, CD);
    step(0, 8'h00, 1, 1, 0, 0, A, CD ? 7'h03 : 7'h00, CD ? 3'd2 : 3'd0, !CD, 0);
    step(0, 8'h00, 1, 1, 0, 0, A, CD ? 7'h01 : 7'h00, CD ? 3'd1 : 3'd0, !CD, CD);
    if (CD) begin
      step(0, 8'h00, 1, 0, 0, 0, A, 7'h01, 3'd1, 0, 1);
      step(0, 8'h00, 1, 0, 0, 0, A, 7'h01, 3'd1, 0, 0);
      step(0, 8'h00, 1, 1, 0, 0, A, 7'h00, 3'd0, 1, 1);
    end
    // DEAD ignores moves and ticks
    step(1, 8'h55, 0, 0, 0, 0, A, 7'h00, 3'd0, 1, CD);
    step(1, 8'h56, 1, 0, 1, 0, A, 7'h00, 3'd0, 1, CD);
    step(0, 8'h00, 0, 0, 0, 1, A, 7'h07, 3'd3, 0, 0);
    step(1, 8'h21, 1, 1, 0, 0, 56'h77777777777721, 7'h03, 3'd2, 0, CD);

    // asynchronous reset mid-frame, checked before any clock edge
    #2 reset = 1'b1;
    #1 check("async_reset", r);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0, 8'h00, 0, 0, 0, 0, A, 7'h07, 3'd3, 0, 0);
    step(1, 8'h30, 0, 0, 0, 0, 56'h77777777777730, 7'h07, 3'd3, 0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dragon_body.md
# dragon_body

Dragon body state block: owns the dragon's segment position chain and live-segment mask, and drives the segment-position and active-segment inputs of the collision detection unit. Once per frame it consumes that unit's sword and sheep collision results to shrink or grow the dragon. Between frames it shifts the chain whenever the dragon head moves. It also reports dragon death to the game-state logic.

## Interface
- `INIT_LEN`, 3: segment count after reset or respawn; legal 1..7.
- `SPAWN_POS`, 8'h77: position loaded into every slot on reset or respawn.
- `COOLDOWN_FRAMES`, 30: frames of hit immunity after an accepted shrink; 1..255. Used only with `DRAGON_HIT_COOLDOWN_EN`.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse at end of frame; collision inputs are sampled on this cycle.
- `head_move`  in  1  one-cycle pulse; the head advances to `head_pos`.
- `head_pos`  in  8  new head position, valid when `head_move`=1.
- `sword_hit`  in  1  sword/dragon collision result for the frame.
- `sheep_hit`  in  1  sheep/dragon collision result for the frame.
- `respawn`  in  1  one-cycle pulse; restores the dragon from any state.
- `dragon_segment_positions`  out  56  slot i at bits [8i+7:8i]; slot 0 is the head.
- `active_dragon_segments`  out  7  bit i=1 when slot i is live; always (1<<len)-1.
- `dragon_length`  out  3  live segment count, 0..7.
- `dragon_dead`  out  1  high in DEAD.
- `dragon_hurt`  out  1  high while hit cooldown is running.

## Operation
- State machine has two states, ALIVE and DEAD. Reset enters ALIVE.
- Reset values: all slots = `SPAWN_POS`; len = `INIT_LEN`; mask = (1<<`INIT_LEN`)-1; `dragon_dead`=0; `dragon_hurt`=0; cooldown counter = 0.
- Shift, in ALIVE on `head_move`: slot0 ← `head_pos`; slot i ← slot i-1 for i=1..6.
  - All 7 slots shift regardless of len.
  - A grown tail therefore appears at the position the old tail vacated.
- Length update, in ALIVE on `frame_tick`:
  - grow = `sheep_hit`.
  - shrink = `sword_hit` AND cooldown counter == 0.
  - grow only: len+1, saturating at 7.
  - shrink only: len-1.
  - grow and shrink together: len unchanged, but the shrink still counts as accepted for cooldown purposes.
- Death: an accepted shrink with len==1 sets len=0 and mask=0, and moves the state to DEAD.
- DEAD:
  - `head_move`, `frame_tick`, `sword_hit` and `sheep_hit` are ignored.
  - Slots hold their values.
  - `dragon_dead`=1.
- `respawn`, in any state: all slots ← `SPAWN_POS`; len ← `INIT_LEN`; cooldown counter ← 0; state ← ALIVE. `respawn` has priority over every other input in the same cycle.
- Mask is derived from len only; it is never held independently.
- `sword_hit`/`sheep_hit` are don't-care outside `frame_tick` cycles.

## Timing
- All outputs are registered. An event on cycle N is visible on cycle N+1.
- `head_move` and `frame_tick` in the same cycle: the shift and the length update are both applied in that one cycle.
- Reset asserted mid-frame takes effect immediately, independent of `clk`. Reset released: the first event is accepted on the first rising edge after deassertion.
- Zero-latency path: none. The collision unit sees updated positions from the cycle after a move.

## Configuration
- `DRAGON_HIT_COOLDOWN_EN` defined:
  - An accepted shrink loads the cooldown counter with `COOLDOWN_FRAMES`.
  - Each later `frame_tick` with counter>0 decrements it.
  - While the counter is nonzero: `sword_hit` is ignored, grow is still accepted, and `dragon_hurt`=1.
- `DRAGON_HIT_COOLDOWN_EN` undefined:
  - No counter is built.
  - Every `sword_hit` on `frame_tick` is accepted.
  - `dragon_hurt` is tied to 0.

## Test plan
- Reset with defaults → all slots 8'h77, mask 7'b000_0111, `dragon_length`=3, `dragon_dead`=0.
- `head_move` with `head_pos`=8'h12, then 8'h13 → slot0=8'h13, slot1=8'h12, slot2=8'h77.
- Four `frame_tick`s with `sheep_hit`=1 from len 5 → len 6, 7, 7, 7; mask 7'b111_1111.
- `frame_tick` with both hits at len 4 → len stays 4. With the macro defined, `dragon_hurt`=1 on the next cycle.
- Cooldown (macro on, `COOLDOWN_FRAMES`=2, len 3):
  - `sword_hit` on 3 consecutive `frame_tick`s → len 2, 2, 2.
  - `sword_hit` on the 4th tick → len 1.
  - Without the macro, the same stimulus gives 2, 1, 0 and DEAD.
- Len 1, `sword_hit` on `frame_tick` → len 0, mask 0, `dragon_dead`=1.
  - A following `head_move` leaves the slots unchanged.
  - `respawn` → ALIVE, len 3, all slots 8'h77.
